// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD CMD-line response path: FSM encoding, CRC7
// polynomial and bit positions inside short (48-bit) and long (136-bit) frames.
package sd_cmd_pkg;

    localparam int SHORT_LEN = 48;
    localparam int LONG_LEN  = 136;
    localparam int FRAME_W   = LONG_LEN;

    // x^7 + x^3 + 1, implicit x^7 dropped
    localparam logic [6:0] CRC_POLY = 7'h09;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CRC   = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam int S_START_BIT = SHORT_LEN - 1;
    localparam int S_TX_BIT    = SHORT_LEN - 2;
    localparam int S_IDX_MSB   = 45;
    localparam int S_IDX_LSB   = 40;
    localparam int S_ARG_MSB   = 39;
    localparam int S_ARG_LSB   = 8;

    localparam int L_START_BIT = LONG_LEN - 1;
    localparam int L_TX_BIT    = LONG_LEN - 2;
    localparam int L_IDX_MSB   = 133;
    localparam int L_IDX_LSB   = 128;
    localparam int L_DATA_MSB  = 127;

    localparam int CRC_MSB = 7;
    localparam int CRC_LSB = 1;
    localparam int END_BIT = 0;

    // first and last CRC-protected bit positions, as bit-counter values
    localparam logic [7:0] CRC_FIRST_S = 8'(SHORT_LEN - 1);
    localparam logic [7:0] CRC_FIRST_L = 8'(L_DATA_MSB);
    localparam logic [7:0] CRC_LAST    = 8'd8;

    localparam logic [5:0] R2_RSVD_IDX = 6'h3F;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 LFSR (SD command/response CRC), MSB-first, one bit per enabled cycle.
// Shared between the response checker and the command serializer.
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;
    logic       fb;

    always_comb begin
        fb    = bit_in ^ crc_q[6];
        crc_d = crc_q;
        if (clr) begin
            crc_d = 7'h00;
        end else if (en) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC_POLY : 7'h00);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_q <= 7'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_resp_checker.sv
// Checks a received SD CMD response frame: serial CRC7, framing bits and index.
// Optional R1 card-status decode into card_err when SD_RESP_STATUS_DECODE_EN is defined.
module sd_cmd_resp_checker
    import sd_cmd_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    input  logic               long_resp,
    input  logic               crc_chk,
    input  logic [5:0]         exp_index,
    output logic               busy,
    output logic               done,
    output logic               ok,
    output logic               err_crc,
    output logic               err_frame,
    output logic               err_index,
    output logic [5:0]         resp_index,
    output logic [127:0]       resp_data,
    output logic               card_err
);

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 long_q, long_d;
    logic                 crc_chk_q, crc_chk_d;
    logic [5:0]           exp_index_q, exp_index_d;
    logic [7:0]           bit_idx_q, bit_idx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ok_q, ok_d;
    logic                 err_crc_q, err_crc_d;
    logic                 err_frame_q, err_frame_d;
    logic                 err_index_q, err_index_d;
    logic [5:0]           resp_index_q, resp_index_d;
    logic [127:0]         resp_data_q, resp_data_d;

    logic                 crc_clr;
    logic                 crc_en;
    logic                 crc_bit;
    logic [6:0]           crc;

    logic                 short_bad;
    logic                 long_bad;
    logic                 chk_frame;
    logic                 chk_crc;
    logic                 chk_index;
    logic                 chk_card;

    assign crc_clr = (state_q == ST_IDLE) && start;
    assign crc_en  = (state_q == ST_CRC);
    assign crc_bit = frame_q[bit_idx_q];

    sd_crc7 u_crc7 (
        .clk    (clk),
        .reset  (reset),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (crc_bit),
        .crc    (crc)
    );

    always_comb begin
        short_bad = frame_q[S_START_BIT] | frame_q[S_TX_BIT] | ~frame_q[END_BIT];
        long_bad  = frame_q[L_START_BIT] | frame_q[L_TX_BIT] | ~frame_q[END_BIT]
                  | (frame_q[L_IDX_MSB:L_IDX_LSB] != R2_RSVD_IDX);
        chk_frame = long_q ? long_bad : short_bad;
        chk_crc   = crc_chk_q & (crc != frame_q[CRC_MSB:CRC_LSB]);
        chk_index = ~long_q & (frame_q[S_IDX_MSB:S_IDX_LSB] != exp_index_q);
`ifdef SD_RESP_STATUS_DECODE_EN
        // R1 card-status error bits live in arg[31:19]
        chk_card  = ~long_q & ~short_bad & (|frame_q[S_ARG_MSB -: 13]);
`else
        chk_card  = 1'b0;
`endif
    end

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        long_d       = long_q;
        crc_chk_d    = crc_chk_q;
        exp_index_d  = exp_index_q;
        bit_idx_d    = bit_idx_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        ok_d         = ok_q;
        err_crc_d    = err_crc_q;
        err_frame_d  = err_frame_q;
        err_index_d  = err_index_q;
        resp_index_d = resp_index_q;
        resp_data_d  = resp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    frame_d     = frame;
                    long_d      = long_resp;
                    crc_chk_d   = crc_chk;
                    exp_index_d = exp_index;
                    bit_idx_d   = long_resp ? CRC_FIRST_L : CRC_FIRST_S;
                    busy_d      = 1'b1;
                    state_d     = ST_CRC;
                end
            end
            ST_CRC: begin
                bit_idx_d = bit_idx_q - 8'd1;
                if (bit_idx_q == CRC_LAST) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                err_crc_d    = chk_crc;
                err_frame_d  = chk_frame;
                err_index_d  = chk_index;
                ok_d         = ~(chk_crc | chk_frame | chk_index | chk_card);
                resp_index_d = long_q ? frame_q[L_IDX_MSB:L_IDX_LSB]
                                      : frame_q[S_IDX_MSB:S_IDX_LSB];
                resp_data_d  = long_q ? frame_q[L_DATA_MSB:0]
                                      : {96'b0, frame_q[S_ARG_MSB:S_ARG_LSB]};
                done_d       = 1'b1;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            frame_q      <= '0;
            long_q       <= 1'b0;
            crc_chk_q    <= 1'b0;
            exp_index_q  <= 6'h00;
            bit_idx_q    <= 8'h00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ok_q         <= 1'b0;
            err_crc_q    <= 1'b0;
            err_frame_q  <= 1'b0;
            err_index_q  <= 1'b0;
            resp_index_q <= 6'h00;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            long_q       <= long_d;
            crc_chk_q    <= crc_chk_d;
            exp_index_q  <= exp_index_d;
            bit_idx_q    <= bit_idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ok_q         <= ok_d;
            err_crc_q    <= err_crc_d;
            err_frame_q  <= err_frame_d;
            err_index_q  <= err_index_d;
            resp_index_q <= resp_index_d;
            resp_data_q  <= resp_data_d;
        end
    end

`ifdef SD_RESP_STATUS_DECODE_EN
    logic card_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            card_err_q <= 1'b0;
        end else if (state_q == ST_CHECK) begin
            card_err_q <= chk_card;
        end
    end

    assign card_err = card_err_q;
`else
    assign card_err = 1'b0;
`endif

    assign busy       = busy_q;
    assign done       = done_q;
    assign ok         = ok_q;
    assign err_crc    = err_crc_q;
    assign err_frame  = err_frame_q;
    assign err_index  = err_index_q;
    assign resp_index = resp_index_q;
    assign resp_data  = resp_data_q;

endmodule
